// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I-subset control path:
// FSM state encodings, opcode constants, ALUop / ALUsrcB codes and
// the packed control word driven towards the datapath.
// The ALU control unit uses the same ALUop codes.
package multicycle_ctrl_pkg;

   // Main control FSM states (4-bit encoding)
   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_R_EXEC  = 4'd3,
      S_R_WB    = 4'd4,
      S_ADDR    = 4'd5,
      S_MEM_RD  = 4'd6,
      S_LD_WB   = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_ILLEGAL = 4'd10,
      S_HALT    = 4'd11
   } state_t;

   // Opcodes recognised by this core (inst[6:0])
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // ALUop codes shared with the ALU control unit
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-input select codes
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // One-hot opcode classification
   typedef struct packed {
      logic is_r;
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_illegal;
   } opc_class_t;

   // Control word decoded from the current state
   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       mem_to_reg;
      logic       halted;
   } ctrl_t;

   // States that wait on mem_ready and run the timeout counter
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the control FSM and the datapath / unified memory.
// Handshake: the controller raises mem_req (with MemRead or MemWrite)
// and holds it, unchanged, until a cycle in which mem_ready is 1; that
// cycle completes the access. mem_ready outside a request is ignored.
interface multicycle_ctrl_if;
   logic [31:0] inst;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        MemRead;
   logic        MemWrite;
   logic        IorD;
   logic        IRwrite;
   logic        PCwrite;
   logic        PCwriteCond;
   logic        PCsrc;
   logic [1:0]  ALUop;
   logic        ALUsrcA;
   logic [1:0]  ALUsrcB;
   logic        RegWrite;
   logic        MemtoReg;
   logic        halted;
   logic        mem_err;

   // Controller side
   modport master (
      input  inst, zero, mem_ready,
      output mem_req, MemRead, MemWrite, IorD, IRwrite, PCwrite, PCwriteCond,
             PCsrc, ALUop, ALUsrcA, ALUsrcB, RegWrite, MemtoReg, halted, mem_err
   );

   // Datapath / memory side
   modport slave (
      output inst, zero, mem_ready,
      input  mem_req, MemRead, MemWrite, IorD, IRwrite, PCwrite, PCwriteCond,
             PCsrc, ALUop, ALUsrcA, ALUsrcB, RegWrite, MemtoReg, halted, mem_err
   );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational classification of the 7-bit opcode into one-hot
// {is_r, is_load, is_store, is_branch, is_illegal}.
module multicycle_ctrl_opcode_class
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output opc_class_t cls
);

   // Decode opcode; anything not recognised is flagged illegal
   always_comb begin
      cls = '0;
      case (opcode)
         OPC_R:      cls.is_r       = 1'b1;
         OPC_LOAD:   cls.is_load    = 1'b1;
         OPC_STORE:  cls.is_store   = 1'b1;
         OPC_BRANCH: cls.is_branch  = 1'b1;
         default:    cls.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core (add/sub/and/or,
// lw, sw, beq). Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables and muxes, and runs the memory request/ready handshake with a
// saturating timeout (MEM_TIMEOUT = 0 disables it).
// Optional build macro: ILLEGAL_TRAP_EN -- illegal opcodes halt the core
// instead of retiring as a 3-cycle NOP.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus,
   output state_t            dbg_state
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   // Count value in the last permitted wait cycle
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             timeout_hit;
   opc_class_t       cls;
   ctrl_t            ctrl;
   logic             unused_inst;

   // Only the opcode field matters here
   assign unused_inst = ^bus.inst[31:7];

   multicycle_ctrl_opcode_class u_opcode_class (
      .opcode (bus.inst[6:0]),
      .cls    (cls)
   );

   // Limit reached in a wait state with no completion this cycle;
   // a mem_ready arriving on the limit cycle still completes the access
   assign timeout_hit = (MEM_TIMEOUT != 0) && is_wait_state(state_q) &&
                        !bus.mem_ready && (cnt_q == CNT_LAST);

   // State, timeout counter and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RESET;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH: begin
            if (timeout_hit)        state_d = S_HALT;
            else if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (cls.is_r)                         state_d = S_R_EXEC;
            else if (cls.is_load || cls.is_store) state_d = S_ADDR;
            else if (cls.is_branch)               state_d = S_BRANCH;
            else                                  state_d = S_ILLEGAL;
         end
         S_R_EXEC: state_d = S_R_WB;
         S_R_WB:   state_d = S_FETCH;
         S_ADDR:   state_d = cls.is_load ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (timeout_hit)        state_d = S_HALT;
            else if (bus.mem_ready) state_d = S_LD_WB;
         end
         S_LD_WB:  state_d = S_FETCH;
         S_MEM_WR: begin
            if (timeout_hit)        state_d = S_HALT;
            else if (bus.mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
         S_ILLEGAL: state_d = S_HALT;
`else
         S_ILLEGAL: state_d = S_FETCH;
`endif
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_RESET;
      endcase
   end

   // Timeout counter: cleared on any state change, counts stalled wait cycles
   always_comb begin
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q | timeout_hit;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (is_wait_state(state_q) && !bus.mem_ready && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Control word decoded from the state; IRwrite/PCwrite are qualified by
   // the completing fetch and PCwriteCond by the ALU zero flag
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.ir_write  = bus.mem_ready;
            ctrl.pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_LD_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RS2;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_src        = 1'b1;
            ctrl.pc_write_cond = bus.zero;
         end
         S_HALT:  ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

   assign bus.mem_req     = ctrl.mem_req;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.IorD        = ctrl.iord;
   assign bus.IRwrite     = ctrl.ir_write;
   assign bus.PCwrite     = ctrl.pc_write;
   assign bus.PCwriteCond = ctrl.pc_write_cond;
   assign bus.PCsrc       = ctrl.pc_src;
   assign bus.ALUop       = ctrl.alu_op;
   assign bus.ALUsrcA     = ctrl.alu_src_a;
   assign bus.ALUsrcB     = ctrl.alu_src_b;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.halted      = ctrl.halted;
   assign bus.mem_err     = mem_err_q;
   assign dbg_state       = state_q;

endmodule
